mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the 9:1 x16 select datapath. Nine requesters
//  share one 16-bit output channel. The block grants one requester at a time, holds the
//  grant for a bounded burst, and drives the 4-bit select code. It also presents the
//  selected word on a valid/ready output port. It sits between the requesting sources
//  and the downstream consumer.
// PARAMETERS
//  N_REQ      9    number of requesters; fixed max 9 (sel codes 0..8, 4'hF = idle)
//  DW         16   data width per requester
//  MAX_BURST  4    max accepted beats per grant before forced release (1..15)
// PORTS
//  clk        in   1          single clock, all state updates on rising edge
//  rst        in   1          synchronous, active-high reset
//  req        in   N_REQ      per-requester request; bit k = requester k
//  data_in    in   N_REQ*DW   packed data; requester k at [k*DW +: DW]
//  grant      out  N_REQ      one-hot grant (all-zero when idle), registered
//  sel        out  4          registered select code: owner index, 4'hF when idle
//  out_data   out  DW         selected word; 16'hFFFF when sel = 4'hF
//  out_valid  out  1          owner word valid
//  out_ready  in   1          consumer accepts; beat = out_valid & out_ready
// BEHAVIOUR
//  Reset values
//  - state=IDLE, ptr=N_REQ-1 (the first search starts at 0), grant=0, sel=4'hF,
//    beat_cnt=0, out_valid=0, out_data=16'hFFFF.
//  - Reset asserted mid-burst aborts the grant at that edge. No beat is counted.
//  FSM IDLE
//  - If |req, pick the first k with req[k]=1, searching ptr+1, ptr+2, ... with wrap at N_REQ.
//  - Register owner=k, grant=1<<k, sel=k, beat_cnt=0, go BUSY.
//  - Latency: req sampled high at edge t gives grant/sel valid after edge t.
//  - If no request, stay IDLE.
//  FSM BUSY
//  - out_valid = req[owner], combinational from registered owner.
//  - On a beat, beat_cnt += 1.
//  - Release occurs at an edge when either condition holds:
//    (a) req[owner] = 0, or
//    (b) a beat occurs with beat_cnt = MAX_BURST-1.
//  - On release: ptr <= owner, grant <= 0, sel <= 4'hF, state <= IDLE.
//  - Each release is followed by one mandatory idle arbitration cycle (bubble).
//    New requests arriving on the release cycle are arbitrated in that IDLE cycle.
//  - A stalled beat (out_valid & ~out_ready) does not count. The grant is held
//    indefinitely while req[owner] stays high.
//  - Requester k must keep data_in[k] stable while out_valid & ~out_ready.
//  Fairness
//  - ptr advances to the last owner on every release.
//  - A requester that stays high after burst exhaustion is re-granted only if no
//    other request is pending. Worst-case wait = (N_REQ-1)*(MAX_BURST+1) cycles
//    with a ready consumer.
//  Datapath
//  - out_data = data_in[sel] for sel 0..8, else 16'hFFFF. The select path is
//    combinational and adds no cycle.
//  - grant is always one-hot or zero. sel == owner index whenever grant != 0.
// STRUCTURE
//  - Package mux_arb_pkg holds:
//    - N_REQ, DW, SEL_W=4, SEL_IDLE=4'hF, DATA_IDLE='1
//    - typedef enum {IDLE,BUSY} arb_state_t
//    - function rr_pick(req, ptr) returning index+found
//  - Sub-module sel_mux9: the combinational 9:1 x DW selector, sel in, out_data out,
//    all-ones default. The arbiter FSM, pointer and beat counter stay in this module.
// TESTING
//  - Reset: hold rst 2 cycles with req=9'h1FF.
//    Expect grant=0, sel=4'hF, out_valid=0, out_data=16'hFFFF. Mid-burst rst drops
//    grant at the next edge.
//  - Single requester: req=9'h004, out_ready=1, data_in[2]=16'h1234.
//    Grant 9'h004 and sel=2 one cycle later. 4 beats of 16'h1234, then release, then
//    1 bubble, then re-grant.
//  - Round robin: req=9'h1FF held, out_ready=1.
//    Grant order 0,1,...,8,0, each 4 beats, separated by 1 idle cycle. No index skipped.
//  - Backpressure: owner 5, out_ready low for 3 cycles after beat 1.
//    beat_cnt frozen, out_data stable. Release only after the 4th accepted beat.
//  - Early drop: owner 3 drops req after 2 beats while req[7] is high.
//    Release next edge, sel=4'hF for 1 cycle, then grant 9'h080.
//  - Wrap: ptr=8 with req=9'h101 → grant requester 0 first, then 8.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, types and the round-robin search helper for the 9:1 x16 arbiter.
package mux_arb_pkg;

    localparam int unsigned N_REQ     = 9;
    localparam int unsigned DW        = 16;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned SEL_W     = 4;
    localparam int unsigned BEAT_W    = 4;

    localparam logic [SEL_W-1:0] SEL_IDLE  = 4'hF;
    localparam logic [DW-1:0]    DATA_IDLE = '1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First requester found searching ptr+1, ptr+2, ... with wrap at N_REQ.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
        pick_t            r;
        int unsigned      c;
        logic [SEL_W-1:0] cidx;
        r.found = 1'b0;
        r.idx   = SEL_IDLE;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            c    = (32'(ptr) + i) % N_REQ;
            cidx = SEL_W'(c);
            if (!r.found && req[cidx]) begin
                r.found = 1'b1;
                r.idx   = cidx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle of the arbiter; master = sources and consumer, slave = arbiter.
interface mux_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] data_in;
    logic [N_REQ-1:0]    grant;
    logic [SEL_W-1:0]    sel;
    logic [DW-1:0]       out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output req,
        output data_in,
        output out_ready,
        input  grant,
        input  sel,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  req,
        input  data_in,
        input  out_ready,
        output grant,
        output sel,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/mux_rr_arbiter_sel_mux9.sv
// Combinational 9:1 x DW word selector; any code outside 0..N_REQ-1 yields all-ones.
module sel_mux9
    import mux_arb_pkg::*;
(
    input  logic [N_REQ*DW-1:0] data_in,
    input  logic [SEL_W-1:0]    sel,
    output logic [DW-1:0]       out_data
);

    always_comb begin
        out_data = DATA_IDLE;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (sel == SEL_W'(k)) begin
                out_data = data_in[k*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter: grants one requester for up to MAX_BURST accepted beats,
// drives the registered select code and presents the owner's word on valid/ready.
module mux_rr_arbiter
    import mux_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mux_rr_arbiter_if.slave bus
);

    arb_state_t        state, state_n;
    logic [SEL_W-1:0]  owner, owner_n;
    logic [SEL_W-1:0]  ptr, ptr_n;
    logic [BEAT_W-1:0] beat_cnt, cnt_n;
    logic [N_REQ-1:0]  grant_q, grant_n;
    logic [SEL_W-1:0]  sel_q, sel_n;

    pick_t pick;
    logic  owner_req;
    logic  beat;
    logic  last_beat;
    logic  release_c;

    assign owner_req     = bus.req[owner];
    assign bus.out_valid = (state == BUSY) && owner_req;
    assign beat          = bus.out_valid && bus.out_ready;
    assign last_beat     = beat && (beat_cnt == BEAT_W'(MAX_BURST - 1));
    assign release_c     = (state == BUSY) && (!owner_req || last_beat);

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= SEL_W'(N_REQ - 1);
            beat_cnt <= '0;
            grant_q  <= '0;
            sel_q    <= SEL_IDLE;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            beat_cnt <= cnt_n;
            grant_q  <= grant_n;
            sel_q    <= sel_n;
        end
    end

    // Arbitration in IDLE, burst accounting and release in BUSY.
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        cnt_n   = beat_cnt;
        grant_n = grant_q;
        sel_n   = sel_q;
        pick    = rr_pick(bus.req, ptr);

        case (state)
            IDLE: begin
                if (pick.found) begin
                    state_n = BUSY;
                    owner_n = pick.idx;
                    grant_n = N_REQ'(1) << pick.idx;
                    sel_n   = pick.idx;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (release_c) begin
                    state_n = IDLE;
                    ptr_n   = owner;
                    grant_n = '0;
                    sel_n   = SEL_IDLE;
                    cnt_n   = '0;
                end else if (beat) begin
                    cnt_n = beat_cnt + BEAT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    sel_mux9 u_sel_mux9 (
        .data_in  (bus.data_in),
        .sel      (sel_q),
        .out_data (bus.out_data)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, single requester, round robin,
// backpressure, early drop and pointer wrap.
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   failures;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int k, input logic [DW-1:0] v);
        bus.data_in[k*DW +: DW] = v;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'h0);
        check({tag, "_sel"}, 32'(bus.sel), 32'hF);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_data"}, 32'(bus.out_data), 32'hFFFF);
    endtask

    task automatic check_owner(input string tag, input int k, input logic [DW-1:0] d);
        logic [N_REQ-1:0] g;
        g = N_REQ'(1) << k;
        check({tag, "_grant"}, 32'(bus.grant), 32'(g));
        check({tag, "_sel"}, 32'(bus.sel), 32'(k));
        check({tag, "_valid"}, 32'(bus.out_valid), 32'h1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(d));
    endtask

    initial begin
        tests         = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.req       = 9'h1FF;
        bus.out_ready = 1'b1;
        bus.data_in   = '0;
        for (int k = 0; k < 9; k++) set_word(k, 16'hA000 | 16'(k));

        // Reset held two cycles with every request high
        tick();
        tick();
        check_idle("reset");

        // Single requester 2: grant a cycle later, 4 beats, release, bubble, re-grant
        rst     = 1'b0;
        bus.req = 9'h004;
        set_word(2, 16'h1234);
        for (int b = 0; b < 4; b++) begin
            tick();
            check_owner("single_beat", 2, 16'h1234);
        end
        tick();
        check_idle("single_bubble");
        tick();
        check_owner("single_regrant", 2, 16'h1234);

        // Reset mid-burst drops the grant at that edge
        rst = 1'b1;
        tick();
        check_idle("midrst");
        rst     = 1'b0;
        bus.req = 9'h000;
        tick();
        check_idle("no_req");

        // Round robin 0..8,0 with all requests held, 4 beats each plus one bubble
        set_word(2, 16'hA002);
        bus.req = 9'h1FF;
        for (int n = 0; n < 10; n++) begin
            tick();
            check_owner("rr_grant", n % 9, 16'hA000 | 16'(n % 9));
            repeat (3) tick();
            check("rr_hold", 32'(bus.sel), 32'(n % 9));
            tick();
            check("rr_bubble", 32'(bus.sel), 32'hF);
        end

        // Backpressure on owner 5: stalls after beat 1 do not count
        bus.req = 9'h020;
        tick();
        check_owner("bp_first", 5, 16'hA005);
        tick();
        bus.out_ready = 1'b0;
        check_owner("bp_after1", 5, 16'hA005);
        repeat (3) begin
            tick();
            check_owner("bp_stall", 5, 16'hA005);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_beat2_grant", 32'(bus.grant), 32'h020);
        tick();
        check("bp_beat3_grant", 32'(bus.grant), 32'h020);
        tick();
        check_idle("bp_release");

        // Early drop: owner 3 leaves after 2 beats while 7 waits
        bus.req = 9'h008;
        tick();
        check_owner("drop_grant", 3, 16'hA003);
        bus.req = 9'h088;
        tick();
        check("drop_hold1", 32'(bus.grant), 32'h008);
        tick();
        check("drop_hold2", 32'(bus.grant), 32'h008);
        bus.req = 9'h080;
        tick();
        check_idle("drop_bubble");
        tick();
        check_owner("drop_next", 7, 16'hA007);

        // Wrap: leave ptr at 8, then req 0 and 8 together -> 0 first, then 8
        bus.req = 9'h100;
        tick();
        check_idle("wrap_bubble7");
        tick();
        check_owner("wrap_own8", 8, 16'hA008);
        bus.req = 9'h001;
        tick();
        check_idle("wrap_bubble8");
        bus.req = 9'h101;
        tick();
        check_owner("wrap_first0", 0, 16'hA000);
        repeat (3) tick();
        tick();
        check_idle("wrap_bubble0");
        tick();
        check_owner("wrap_then8", 8, 16'hA008);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
